// File: rtl/usb_defines.sv
`default_nettype none
// ============================================================================
// Module   : usb_defines (package)
// Purpose  : Shared bus widths, arbiter state encoding and a small helper
//            used by the USB core CSR/EP-status bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package usb_defines;

    // Core CSR/EP-status bus geometry
    localparam int C_ADDR_W = 12;
    localparam int C_DATA_W = 16;

    // Arbiter state: IDLE has bus_cyc low, BUSY has bus_cyc high
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Width of an index into n requesters; never zero so a single-requester
    // build still has a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_bus_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_bus_arb_if
// Purpose  : Requester-side and core-side signals of the CSR/EP-status bus
//            arbiter. The master modport is the arbiter's view, the slave
//            modport is the view of the surrounding requesters and core.
// Revision : 1.0 - initial release
// ============================================================================
interface usb_bus_arb_if
    import usb_defines::*;
#(
    parameter int N_REQ = 2
);

    // Requester side
    logic [N_REQ-1:0]          req_cyc;
    logic [N_REQ-1:0]          req_we;
    logic [N_REQ-1:0]          req_lock;
    logic [C_ADDR_W*N_REQ-1:0] req_addr;
    logic [C_DATA_W*N_REQ-1:0] req_din;
    logic [N_REQ-1:0]          req_ack;
    logic [N_REQ-1:0]          req_err;
    logic [C_DATA_W-1:0]       req_dout;

    // Core side
    logic [C_ADDR_W-1:0]       bus_addr;
    logic [C_DATA_W-1:0]       bus_din;
    logic                      bus_we;
    logic                      bus_cyc;
    logic                      bus_ack;
    logic [C_DATA_W-1:0]       bus_dout;

    // Current owner, one-hot
    logic [N_REQ-1:0]          grant;

    modport master (
        input  req_cyc, req_we, req_lock, req_addr, req_din,
        output req_ack, req_err, req_dout,
        output bus_addr, bus_din, bus_we, bus_cyc,
        input  bus_ack, bus_dout,
        output grant
    );

    modport slave (
        output req_cyc, req_we, req_lock, req_addr, req_din,
        input  req_ack, req_err, req_dout,
        input  bus_addr, bus_din, bus_we, bus_cyc,
        output bus_ack, bus_dout,
        input  grant
    );

endinterface
`default_nettype wire

// File: rtl/usb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : usb_rr_pick
// Purpose  : Combinational round-robin first-one finder. Searches the masked
//            request vector starting at i_ptr, wrapping modulo N_REQ, and
//            returns the winner as one-hot and as an index.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rr_pick
    import usb_defines::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = idx_w(N_REQ)
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [IW-1:0]    i_ptr,
    input  wire logic [N_REQ-1:0] i_mask,
    output logic      [N_REQ-1:0] o_onehot,
    output logic      [IW-1:0]    o_idx,
    output logic                  o_valid
);

    logic [N_REQ-1:0] w_cand;

    assign w_cand = i_req & i_mask;

    // Walk the candidates from the pointer onward and keep the first hit
    always_comb begin
        int  j;
        logic w_found;
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        j        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(i_ptr) + k) % N_REQ;
            if (!w_found && w_cand[j]) begin
                w_found     = 1'b1;
                o_onehot[j] = 1'b1;
                o_idx       = IW'(j);
            end
        end
        o_valid = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/usb_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : usb_bus_arb
// Purpose  : Round-robin arbiter sharing the USB core CSR/EP-status bus
//            between N_REQ requesters. Latches the winning transaction,
//            forces one idle cycle between transactions, supports a lock
//            for read-modify-write and aborts on a missing bus_ack.
// Revision : 1.0 - initial release
// ============================================================================
module usb_bus_arb
    import usb_defines::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255,
    parameter int TW      = $clog2(TIMEOUT + 2)
) (
    input  wire logic     clk,
    input  wire logic     rst,
    usb_bus_arb_if.master bif
);

    localparam int C_IW = idx_w(N_REQ);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [N_REQ-1:0]    r_grant;
    logic [N_REQ-1:0]    w_grant_nxt;
    logic [C_IW-1:0]     r_owner;
    logic [C_IW-1:0]     w_owner_nxt;
    logic [C_IW-1:0]     w_owner_inc;
    logic [C_IW-1:0]     r_ptr;
    logic [C_IW-1:0]     w_ptr_nxt;
    logic                r_lock;
    logic                w_lock_nxt;
    logic [TW-1:0]       r_cnt;
    logic [TW-1:0]       w_cnt_nxt;
    logic                w_load;
    logic                w_timeout;

    logic [N_REQ-1:0]    w_mask;
    logic [N_REQ-1:0]    w_pick_onehot;
    logic [C_IW-1:0]     w_pick_idx;
    logic                w_pick_valid;

    logic                w_owner_cyc;
    logic                w_owner_lock;
    logic [C_ADDR_W-1:0] w_sel_addr;
    logic [C_DATA_W-1:0] w_sel_din;
    logic                w_sel_we;

    logic [C_ADDR_W-1:0] r_bus_addr;
    logic [C_DATA_W-1:0] r_bus_din;
    logic                r_bus_we;

    // A held lock restricts eligibility to the locked owner
    assign w_mask = r_lock ? r_grant : {N_REQ{1'b1}};

    usb_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (C_IW)
    ) u_pick (
        .i_req    (bif.req_cyc),
        .i_ptr    (r_ptr),
        .i_mask   (w_mask),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    assign w_sel_addr   = bif.req_addr[int'(w_pick_idx)*C_ADDR_W +: C_ADDR_W];
    assign w_sel_din    = bif.req_din[int'(w_pick_idx)*C_DATA_W +: C_DATA_W];
    assign w_sel_we     = bif.req_we[w_pick_idx];
    assign w_owner_cyc  = bif.req_cyc[r_owner];
    assign w_owner_lock = bif.req_lock[r_owner];
    assign w_owner_inc  = (int'(r_owner) == N_REQ - 1) ? '0 : r_owner + 1'b1;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            assign w_timeout = (r_cnt == TW'(TIMEOUT));
        end else begin : g_no_wdog
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Next-state, bookkeeping and requester-facing responses
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_owner_nxt  = r_owner;
        w_ptr_nxt    = r_ptr;
        w_lock_nxt   = r_lock;
        w_cnt_nxt    = r_cnt;
        w_load       = 1'b0;
        bif.req_ack  = '0;
        bif.req_err  = '0;
        bif.req_dout = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_pick_onehot;
                    w_owner_nxt = w_pick_idx;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bif.bus_ack) begin
                    // Ack beats both withdrawal and timeout
                    bif.req_ack  = r_grant;
                    bif.req_dout = bif.bus_dout;
                    w_state_nxt  = ST_IDLE;
                    w_ptr_nxt    = w_owner_inc;
                    w_lock_nxt   = w_owner_lock;
                    w_grant_nxt  = w_owner_lock ? r_grant : '0;
                end else if (!w_owner_cyc) begin
                    // Owner withdrew; the core aborts on bus_cyc falling
                    w_state_nxt  = ST_IDLE;
                    w_ptr_nxt    = w_owner_inc;
                    w_lock_nxt   = 1'b0;
                    w_grant_nxt  = '0;
                end else if (w_timeout) begin
                    bif.req_err  = r_grant;
                    w_state_nxt  = ST_IDLE;
                    w_ptr_nxt    = w_owner_inc;
                    w_lock_nxt   = 1'b0;
                    w_grant_nxt  = '0;
                end else begin
                    w_cnt_nxt    = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops bus_cyc immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ownership, round-robin pointer, lock and watchdog counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_lock  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lock  <= w_lock_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Transaction latch: captured once at grant, held for the whole cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_addr <= '0;
            r_bus_din  <= '0;
            r_bus_we   <= 1'b0;
        end else if (w_load) begin
            r_bus_addr <= w_sel_addr;
            r_bus_din  <= w_sel_din;
            r_bus_we   <= w_sel_we;
        end
    end

    assign bif.bus_cyc  = (r_state == ST_BUSY);
    assign bif.bus_addr = r_bus_addr;
    assign bif.bus_din  = r_bus_din;
    assign bif.bus_we   = r_bus_we;
    assign bif.grant    = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_usb_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_bus_arb
// Purpose  : Directed self-checking bench for usb_bus_arb (2 requesters,
//            255-cycle watchdog).
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_bus_arb;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   errs;

    usb_bus_arb_if #(.N_REQ(2)) bif ();

    usb_bus_arb #(
        .N_REQ   (2),
        .TIMEOUT (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Directed sequence; inputs change and outputs are sampled on negedges
    initial begin
        logic [1:0] exp_g;
        n_tests = 0;
        n_fail  = 0;
        errs    = 0;
        rst          = 1'b1;
        bif.req_cyc  = '0;
        bif.req_we   = '0;
        bif.req_lock = '0;
        bif.req_addr = '0;
        bif.req_din  = '0;
        bif.bus_ack  = 1'b0;
        bif.bus_dout = '0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_cyc",   bif.bus_cyc,  0);
        chk("rst_grant", bif.grant,    0);
        chk("rst_addr",  bif.bus_addr, 0);
        chk("rst_we",    bif.bus_we,   0);
        rst = 1'b0;

        // Requester 0 reads 0x801, ack three cycles after bus_cyc rises
        bif.req_addr = {12'h000, 12'h801};
        bif.req_cyc  = 2'b01;
        @(negedge clk);
        chk("t1_cyc",   bif.bus_cyc,  1);
        chk("t1_grant", bif.grant,    2'b01);
        chk("t1_addr",  bif.bus_addr, 12'h801);
        chk("t1_we",    bif.bus_we,   0);
        repeat (2) begin
            @(negedge clk);
            chk("t1_noack", bif.req_ack, 0);
        end
        @(negedge clk);
        bif.bus_dout = 16'h1234;
        bif.bus_ack  = 1'b1;
        #1;
        chk("t1_ack",  bif.req_ack,  2'b01);
        chk("t1_dout", bif.req_dout, 16'h1234);
        @(negedge clk);
        chk("t1_gap",      bif.bus_cyc, 0);
        chk("t1_ack_idle", bif.req_ack, 0);
        bif.bus_ack = 1'b0;
        bif.req_cyc = 2'b00;

        // Reset in the middle of a requester-1 transaction
        bif.req_addr = {12'h123, 12'h456};
        bif.req_cyc  = 2'b10;
        @(negedge clk);
        chk("rb_grant", bif.grant,    2'b10);
        chk("rb_addr",  bif.bus_addr, 12'h123);
        rst = 1'b1;
        #1;
        chk("rb_cyc0",   bif.bus_cyc, 0);
        chk("rb_grant0", bif.grant,   0);
        chk("rb_ack0",   bif.req_ack, 0);
        bif.req_cyc = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Both requesting: grants alternate 0,1,0,1 with one idle cycle between
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
            chk("alt_cyc",   bif.bus_cyc, 1);
            chk("alt_grant", bif.grant,   exp_g);
            bif.req_cyc  = 2'b11;
            bif.bus_dout = 16'(16'hA000 + i);
            bif.bus_ack  = 1'b1;
            #1;
            chk("alt_ack",  bif.req_ack,  exp_g);
            chk("alt_dout", bif.req_dout, 16'(16'hA000 + i));
            @(negedge clk);
            chk("alt_gap", bif.bus_cyc, 0);
            bif.bus_ack = 1'b0;
            bif.req_cyc = (i == 3) ? 2'b00 : (2'b11 & ~exp_g);
            @(negedge clk);
        end

        // Locked read-modify-write by requester 1
        bif.req_addr = {12'h840, 12'h000};
        bif.req_din  = {16'hBEEF, 16'h0000};
        bif.req_we   = 2'b10;
        bif.req_lock = 2'b10;
        bif.req_cyc  = 2'b10;
        @(negedge clk);
        chk("lk_grant", bif.grant,    2'b10);
        chk("lk_addr",  bif.bus_addr, 12'h840);
        chk("lk_din",   bif.bus_din,  16'hBEEF);
        chk("lk_we",    bif.bus_we,   1);
        bif.req_cyc  = 2'b11;
        bif.bus_dout = 16'h0000;
        bif.bus_ack  = 1'b1;
        #1;
        chk("lk_ack", bif.req_ack, 2'b10);
        @(negedge clk);
        chk("lk_gap",  bif.bus_cyc, 0);
        chk("lk_held", bif.grant,   2'b10);
        bif.bus_ack = 1'b0;
        bif.req_cyc = 2'b01;
        @(negedge clk);
        chk("lk_block_cyc",   bif.bus_cyc, 0);
        chk("lk_block_grant", bif.grant,   2'b10);
        bif.req_din  = {16'h0042, 16'h0000};
        bif.req_lock = 2'b00;
        bif.req_cyc  = 2'b11;
        @(negedge clk);
        chk("lk2_grant", bif.grant,   2'b10);
        chk("lk2_din",   bif.bus_din, 16'h0042);
        bif.bus_ack = 1'b1;
        #1;
        chk("lk2_ack", bif.req_ack, 2'b10);
        @(negedge clk);
        chk("lk2_release", bif.grant, 0);
        bif.bus_ack = 1'b0;
        bif.req_cyc = 2'b01;
        bif.req_we  = 2'b00;
        @(negedge clk);
        chk("lk3_grant", bif.grant,   2'b01);
        chk("lk3_cyc",   bif.bus_cyc, 1);
        bif.bus_ack = 1'b1;
        #1;
        chk("lk3_ack", bif.req_ack, 2'b01);
        @(negedge clk);
        bif.bus_ack = 1'b0;
        bif.req_cyc = 2'b00;

        // Watchdog: core never acks requester 1
        bif.req_cyc = 2'b11;
        @(negedge clk);
        chk("wd_grant", bif.grant,   2'b10);
        chk("wd_cyc",   bif.bus_cyc, 1);
        repeat (254) begin
            @(negedge clk);
            if (bif.req_err != 2'b00) errs++;
        end
        chk("wd_early_err", errs, 0);
        @(negedge clk);
        chk("wd_err",      bif.req_err, 2'b10);
        chk("wd_err_ack",  bif.req_ack, 0);
        chk("wd_cyc_hold", bif.bus_cyc, 1);
        @(negedge clk);
        chk("wd_drop",    bif.bus_cyc, 0);
        chk("wd_err_clr", bif.req_err, 0);
        bif.req_cyc = 2'b01;
        @(negedge clk);
        chk("wd_next", bif.grant, 2'b01);

        // Withdrawal: owner 0 drops req_cyc in its second BUSY cycle
        @(negedge clk);
        bif.req_cyc = 2'b00;
        #1;
        chk("wdr_ack",  bif.req_ack,  0);
        chk("wdr_err",  bif.req_err,  0);
        chk("wdr_dout", bif.req_dout, 0);
        @(negedge clk);
        chk("wdr_cyc",   bif.bus_cyc, 0);
        chk("wdr_grant", bif.grant,   0);
        chk("wdr_err2",  bif.req_err, 0);
        bif.req_cyc = 2'b11;
        @(negedge clk);
        chk("wdr_ptr", bif.grant, 2'b10);
        bif.bus_ack = 1'b1;
        #1;
        chk("wdr_fin_ack", bif.req_ack, 2'b10);
        @(negedge clk);
        bif.bus_ack = 1'b0;
        bif.req_cyc = 2'b00;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
